// File: rtl/sysctl_pkg.sv
// Shared register offsets, control-bit positions and reset constants for the
// 6502 board system-control block.
package sysctl_pkg;

    localparam int unsigned PORT_BASE       = 0;
    localparam logic [3:0]  CLKDIV_ADDR     = 4'h8;
    localparam logic [3:0]  TRELOAD_LO_ADDR = 4'h9;
    localparam logic [3:0]  TRELOAD_HI_ADDR = 4'hA;
    localparam logic [3:0]  TCTRL_ADDR      = 4'hB;
    localparam logic [3:0]  ANIM_ADDR       = 4'hC;

    localparam int unsigned TCTRL_EN      = 0;
    localparam int unsigned TCTRL_IRQ_EN  = 1;
    localparam int unsigned TCTRL_ONESHOT = 2;
    localparam int unsigned TCTRL_PEND    = 7;

    localparam logic [7:0] ANIM_RESET = 8'h01;

    function automatic logic [7:0] rotl8(logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/sysctl_timer.sv
// Reloadable interval timer: counts down on CPU-cycle ticks, flags expiry as a
// pending bit and drives a registered active-low interrupt.
module sysctl_timer
    import sysctl_pkg::*;
#(
    parameter int unsigned TIMER_W = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_reload_lo,
    input  logic       wr_reload_hi,
    input  logic       wr_ctrl,
    input  logic [7:0] wdata,
    output logic [7:0] ctrl_rdata,
    output logic [7:0] reload_lo_rdata,
    output logic [7:0] reload_hi_rdata,
    output logic       irq_n
);

    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic               enable_q, enable_d;
    logic               irq_en_q, irq_en_d;
    logic               oneshot_q, oneshot_d;
    logic               pending_q, pending_d;
    logic               irq_n_q;
    logic               expire;
    logic [15:0]        reload_ext;

    // Zero-extended view so the high byte reads 0 for narrow timers.
    assign reload_ext = 16'(reload_q);

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        oneshot_d = oneshot_q;
        pending_d = pending_q;
        expire    = 1'b0;
        if (tick) begin
            if (wr_reload_lo) reload_d = TIMER_W'({reload_ext[15:8], wdata});
            if (wr_reload_hi) reload_d = TIMER_W'({wdata, reload_ext[7:0]});

            if (wr_ctrl && wdata[TCTRL_EN] && !enable_q) begin
                count_d = reload_q;
            end else if (enable_q) begin
                if (count_q != '0) begin
                    count_d = count_q - TIMER_W'(1);
                end else begin
                    expire = 1'b1;
                    if (oneshot_q) enable_d = 1'b0;
                    else           count_d  = reload_q;
                end
            end

            if (wr_ctrl) begin
                enable_d  = wdata[TCTRL_EN];
                irq_en_d  = wdata[TCTRL_IRQ_EN];
                oneshot_d = wdata[TCTRL_ONESHOT];
                if (wdata[TCTRL_PEND]) pending_d = 1'b0;
            end
            // A simultaneous clear and expiry leaves the interrupt pending.
            if (expire) pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            reload_q  <= '0;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            oneshot_q <= 1'b0;
            pending_q <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            oneshot_q <= oneshot_d;
            pending_q <= pending_d;
            irq_n_q   <= ~(pending_q & irq_en_q);
        end
    end

    assign ctrl_rdata      = {pending_q, 4'b0000, oneshot_q, irq_en_q, enable_q};
    assign reload_lo_rdata = reload_ext[7:0];
    assign reload_hi_rdata = reload_ext[15:8];
    assign irq_n           = irq_n_q;

endmodule

// File: rtl/sysctl_regs.sv
// System-control block: glitch-free CPU clock divider, byte output ports with a
// reset-time LED animation, and an interval timer behind the bifrost select.
module sysctl_regs
    import sysctl_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned DIV_W         = 9,
    parameter int unsigned DIV_SEL_RESET = 2,
    parameter int unsigned TIMER_W       = 16,
    parameter logic [7:0]  LED_RESET     = 8'hC3,
    parameter int unsigned ANIM_SHIFT    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cs_n,
    input  logic                   rw,
    input  logic [3:0]             addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   data_oe,
    output logic                   clockout,
    output logic [8*NUM_PORTS-1:0] ports,
    output logic [7:0]             leds,
    output logic                   irq_n
);

    localparam int unsigned SEL_W   = (DIV_W > 1) ? $clog2(DIV_W) : 1;
    localparam int unsigned PORTS_W = 8 * NUM_PORTS;
    localparam logic [PORTS_W-1:0] PORT_RESET = PORTS_W'(LED_RESET);

    logic [DIV_W-1:0]              cnt_q;
    logic [SEL_W-1:0]              div_sel_q, div_sel_d;
    logic [SEL_W-1:0]              pending_sel_q, pending_sel_d;
    logic [SEL_W-1:0]              sel_wr;
    logic                          clockout_q;
    logic                          tick;
    logic                          wr_en;
    logic [NUM_PORTS-1:0][7:0]     port_q, port_d;
    logic                          anim_q, anim_d;
    logic [7:0]                    anim_pat_q, anim_pat_d;
    logic [ANIM_SHIFT-1:0]         anim_cnt_q, anim_cnt_d;
    logic [7:0]                    tctrl_rdata, treload_lo_rdata, treload_hi_rdata;

    // tick marks the master clock on which phi2 falls; bus writes commit there.
    assign tick   = clockout_q & ~cnt_q[div_sel_q];
    assign wr_en  = tick & ~cs_n & ~rw;
    assign sel_wr = (32'(data_in) >= DIV_W) ? SEL_W'(DIV_W - 1) : SEL_W'(data_in);

    // New tap only takes effect when every tap is high, so no pulse is cut short.
    always_comb begin
        div_sel_d     = div_sel_q;
        pending_sel_d = pending_sel_q;
        if (&cnt_q) div_sel_d = pending_sel_q;
        if (wr_en && addr == CLKDIV_ADDR) pending_sel_d = sel_wr;
    end

    always_comb begin
        port_d = port_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (wr_en && 32'(addr) == PORT_BASE + i) port_d[i] = data_in;
        end
    end

    always_comb begin
        anim_d     = anim_q;
        anim_cnt_d = anim_cnt_q;
        anim_pat_d = anim_pat_q;
        if (anim_q) begin
            anim_cnt_d = anim_cnt_q + ANIM_SHIFT'(1);
            if (&anim_cnt_q) anim_pat_d = rotl8(anim_pat_q);
        end
        if (wr_en && addr == ANIM_ADDR) anim_d = data_in[0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            clockout_q    <= 1'b0;
            div_sel_q     <= SEL_W'(DIV_SEL_RESET);
            pending_sel_q <= SEL_W'(DIV_SEL_RESET);
            port_q        <= PORT_RESET;
            anim_q        <= 1'b1;
            anim_pat_q    <= ANIM_RESET;
            anim_cnt_q    <= '0;
        end else begin
            cnt_q         <= cnt_q + DIV_W'(1);
            clockout_q    <= cnt_q[div_sel_q];
            div_sel_q     <= div_sel_d;
            pending_sel_q <= pending_sel_d;
            port_q        <= port_d;
            anim_q        <= anim_d;
            anim_pat_q    <= anim_pat_d;
            anim_cnt_q    <= anim_cnt_d;
        end
    end

    sysctl_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clock          (clock),
        .reset          (reset),
        .tick           (tick),
        .wr_reload_lo   (wr_en && addr == TRELOAD_LO_ADDR),
        .wr_reload_hi   (wr_en && addr == TRELOAD_HI_ADDR),
        .wr_ctrl        (wr_en && addr == TCTRL_ADDR),
        .wdata          (data_in),
        .ctrl_rdata     (tctrl_rdata),
        .reload_lo_rdata(treload_lo_rdata),
        .reload_hi_rdata(treload_hi_rdata),
        .irq_n          (irq_n)
    );

    always_comb begin
        data_out = 8'h00;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (32'(addr) == PORT_BASE + i) data_out = port_q[i];
        end
        case (addr)
            CLKDIV_ADDR:     data_out = 8'(div_sel_q);
            TRELOAD_LO_ADDR: data_out = treload_lo_rdata;
            TRELOAD_HI_ADDR: data_out = treload_hi_rdata;
            TCTRL_ADDR:      data_out = tctrl_rdata;
            ANIM_ADDR:       data_out = {7'b0000000, anim_q};
            default:         ;
        endcase
    end

    assign data_oe  = ~cs_n & rw & clockout_q;
    assign clockout = clockout_q;
    assign ports    = port_q;
    assign leds     = anim_q ? anim_pat_q : port_q[0];

endmodule

// File: tb/tb_sysctl_regs.sv
// Bench for sysctl_regs: cycle-by-cycle comparison against a behavioural model,
// a register read-back table, hand sequences for divider/timer/reset corners.
module tb_sysctl_regs;

    localparam int NP = 2;
    localparam int DW = 9;
    localparam int AS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        rw;
    logic [3:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        clockout;
    logic [15:0] ports;
    logic [7:0]  leds;
    logic        irq_n;

    always #5 clock = ~clock;

    sysctl_regs #(
        .NUM_PORTS    (NP),
        .DIV_W        (DW),
        .DIV_SEL_RESET(2),
        .TIMER_W      (16),
        .LED_RESET    (8'hC3),
        .ANIM_SHIFT   (AS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .cs_n    (cs_n),
        .rw      (rw),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .data_oe (data_oe),
        .clockout(clockout),
        .ports   (ports),
        .leds    (leds),
        .irq_n   (irq_n)
    );

    // Behavioural model state
    int m_cnt, m_sel, m_psel, m_pat, m_acnt, m_count, m_reload, tick_cnt;
    int m_port[NP];
    bit m_clk, m_anim, m_en, m_ie, m_os, m_pend, m_irqn, m_tick;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_sel = 2; m_psel = 2; m_clk = 0;
        m_port[0] = 'hC3; m_port[1] = 0;
        m_anim = 1; m_pat = 1; m_acnt = 0;
        m_count = 0; m_reload = 0;
        m_en = 0; m_ie = 0; m_os = 0; m_pend = 0; m_irqn = 1; m_tick = 0;
    endtask

    function automatic int model_read(input int a);
        if (a < NP) return m_port[a];
        case (a)
            8:  return m_sel;
            9:  return m_reload & 255;
            10: return (m_reload >> 8) & 255;
            11: return (int'(m_pend) << 7) | (int'(m_os) << 2) | (int'(m_ie) << 1) | int'(m_en);
            12: return int'(m_anim);
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit newclk, wr, expire;
        int a, d;
        a = int'(addr);
        d = int'(data_in);
        newclk = ((m_cnt >> m_sel) & 1) != 0;
        m_tick = m_clk && !newclk;
        if (m_tick) tick_cnt++;
        wr = m_tick && !cs_n && !rw;
        m_irqn = !(m_pend && m_ie);
        if (m_cnt == (1 << DW) - 1) m_sel = m_psel;
        m_cnt = (m_cnt + 1) % (1 << DW);
        if (m_anim) begin
            m_acnt++;
            if (m_acnt == (1 << AS)) begin
                m_acnt = 0;
                m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
            end
        end
        if (m_tick) begin
            expire = 0;
            if (wr && a == 11 && d[0] && !m_en) m_count = m_reload;
            else if (m_en) begin
                if (m_count > 0) m_count--;
                else begin
                    expire = 1;
                    if (m_os) m_en = 0;
                    else m_count = m_reload;
                end
            end
            if (wr && a == 11) begin
                m_en = d[0]; m_ie = d[1]; m_os = d[2];
                if (d[7]) m_pend = 0;
            end
            if (expire) m_pend = 1;
        end
        if (wr) begin
            if (a < NP) m_port[a] = d;
            else if (a == 8) m_psel = (d >= DW) ? DW - 1 : d;
            else if (a == 9) m_reload = (m_reload & 'hFF00) | d;
            else if (a == 10) m_reload = (m_reload & 'hFF) | (d << 8);
            else if (a == 12) m_anim = d[0];
        end
        m_clk = newclk;
    endtask

    task automatic step1();
        logic [34:0] act, exp;
        @(posedge clock);
        model_edge();
        #1;
        act = {clockout, data_oe, irq_n, leds, data_out, ports};
        exp = {m_clk, (!cs_n && rw && m_clk), m_irqn,
               m_anim ? 8'(m_pat) : 8'(m_port[0]), 8'(model_read(int'(addr))),
               8'(m_port[1]), 8'(m_port[0])};
        chk("cycle", 64'(act), 64'(exp));
    endtask

    task automatic bus_write(input int a, input int d);
        int n = 0;
        cs_n = 0; rw = 0; addr = 4'(a); data_in = 8'(d);
        do begin
            step1();
            n++;
        end while (!m_tick && n < 1100);
        if (!m_tick) begin
            checks++;
            $display("FAIL bus_write_timeout: addr %0h saw no tick in %0d clocks", a, n);
        end
        cs_n = 1; rw = 1;
    endtask

    task automatic rd_chk(input string name, input int a, input logic [7:0] e);
        addr = 4'(a); rw = 1; cs_n = 1;
        #1;
        chk(name, 64'(data_out), 64'(e));
    endtask

    task automatic wait_irq_low(input string name);
        int n = 0;
        while (irq_n !== 1'b0 && n < 300) begin
            step1();
            n++;
        end
        if (irq_n !== 1'b0) begin
            checks++;
            $display("FAIL %s: irq_n still %b after %0d clocks, expected 0", name, irq_n, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int hi, t0, e1, e2, n;

        vecs[0] = '{4'h1, 8'hA5, 8'hA5};
        vecs[1] = '{4'h0, 8'h3C, 8'h3C};
        vecs[2] = '{4'h2, 8'h77, 8'h00};
        vecs[3] = '{4'hD, 8'h11, 8'h00};
        vecs[4] = '{4'hF, 8'hFF, 8'h00};
        vecs[5] = '{4'h9, 8'h03, 8'h03};
        vecs[6] = '{4'hA, 8'h12, 8'h12};
        vecs[7] = '{4'hA, 8'h00, 8'h00};
        vecs[8] = '{4'hC, 8'h00, 8'h00};

        tick_cnt = 0;
        reset = 1; cs_n = 1; rw = 1; addr = 0; data_in = 0;
        #12;
        chk("rst_clockout", 64'(clockout), 64'(0));
        chk("rst_irq_n",    64'(irq_n),    64'(1));
        chk("rst_leds",     64'(leds),     64'(8'h01));
        chk("rst_ports",    64'(ports),    64'(16'h00C3));
        chk("rst_data_oe",  64'(data_oe),  64'(0));
        chk("rst_rd_port0", 64'(data_out), 64'(8'hC3));
        @(negedge clock);
        reset = 0;
        model_reset();

        // Idle: period-8 phi2, rotating LED pattern
        hi = 0;
        repeat (16) begin
            step1();
            if (clockout) hi++;
        end
        chk("clk_duty_div8", 64'(hi), 64'(8));
        chk("anim_first_step", 64'(leds), 64'(8'h02));
        repeat (112) step1();
        chk("anim_wrap", 64'(leds), 64'(8'h01));

        // Stop animation, then PORT0 write with cs_n held for the whole cycle
        bus_write(12, 0);
        repeat (3) step1();
        bus_write(0, 'h5A);
        chk("leds_port0", 64'(leds), 64'(8'h5A));
        chk("ports_port0", 64'(ports[7:0]), 64'(8'h5A));
        rd_chk("rd_port0", 0, 8'h5A);
        rd_chk("rd_anim", 12, 8'h00);

        for (int i = 0; i < 9; i++) begin
            bus_write(int'(vecs[i].a), int'(vecs[i].wd));
            rd_chk("table_rd", int'(vecs[i].a), vecs[i].rd);
        end

        // Divider switch only at cnt all-ones
        bus_write(8, 0);
        rd_chk("clkdiv_before_switch", 8, 8'h02);
        n = 0;
        while (m_sel != 0 && n < 600) begin
            step1();
            n++;
        end
        rd_chk("clkdiv_after_switch", 8, 8'h00);
        hi = 0;
        repeat (8) begin
            step1();
            if (clockout) hi++;
        end
        chk("clk_duty_div2", 64'(hi), 64'(4));

        // Periodic timer, reload 3
        bus_write(11, 'h03);
        t0 = tick_cnt;
        wait_irq_low("irq_first");
        e1 = tick_cnt;
        chk("irq_first_ticks", 64'(e1 - t0), 64'(4));
        bus_write(11, 'h83);
        chk("irq_low_at_clear", 64'(irq_n), 64'(0));
        step1();
        chk("irq_cleared", 64'(irq_n), 64'(1));
        wait_irq_low("irq_second");
        e2 = tick_cnt;
        chk("irq_period_ticks", 64'(e2 - e1), 64'(4));

        // Oneshot with reload 0
        bus_write(9, 0);
        bus_write(11, 'h80);
        bus_write(11, 'h07);
        t0 = tick_cnt;
        wait_irq_low("oneshot_irq");
        chk("oneshot_ticks", 64'(tick_cnt - t0), 64'(1));
        rd_chk("oneshot_tctrl", 11, 8'h86);
        bus_write(11, 'h86);
        repeat (20) step1();
        rd_chk("oneshot_no_repeat", 11, 8'h06);
        chk("oneshot_irq_high", 64'(irq_n), 64'(1));

        // Random bus traffic against the model
        repeat (1500) begin
            cs_n = ($urandom_range(0, 2) == 0);
            rw = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            data_in = (addr == 4'h8) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            step1();
        end
        cs_n = 1; rw = 1;

        // Reset in the middle of a running timer with an interrupt pending
        bus_write(8, 1);
        bus_write(12, 0);
        bus_write(1, 'h99);
        bus_write(9, 1);
        bus_write(10, 0);
        bus_write(11, 'h80);
        bus_write(11, 'h03);
        wait_irq_low("pre_reset_irq");
        n = 0;
        while (!m_clk && n < 1100) begin
            step1();
            n++;
        end
        cs_n = 0; rw = 1; addr = 0;
        #1;
        reset = 1;
        #1;
        chk("mid_rst_clockout", 64'(clockout), 64'(0));
        chk("mid_rst_irq_n",    64'(irq_n),    64'(1));
        chk("mid_rst_leds",     64'(leds),     64'(8'h01));
        chk("mid_rst_ports",    64'(ports),    64'(16'h00C3));
        chk("mid_rst_data_oe",  64'(data_oe),  64'(0));
        rd_chk("mid_rst_clkdiv", 8, 8'h02);
        rd_chk("mid_rst_tctrl", 11, 8'h00);
        rd_chk("mid_rst_anim", 12, 8'h01);
        @(negedge clock);
        reset = 0;
        model_reset();
        repeat (20) step1();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sysctl_regs.md
Name: sysctl_regs

Overview:
- Parametrised bus-attached system-control block for the 6502 board.
- Generates the CPU clock from the 8 MHz master clock with a software-selectable divider, switched glitch-free.
- Provides NUM_PORTS byte-wide output registers; port 0 drives the LEDs and can be overridden by a reset-time LED animation.
- Adds a reloadable interval timer with an active-low IRQ; sits behind the address decoder's bifrost chip select.

Parameters:
- NUM_PORTS, 2, number of byte output registers (1..8); port 0 is the LED port.
- DIV_W, 9, width of the free-running divider counter.
- DIV_SEL_RESET, 2, divider tap selected at reset (8 MHz / 2^(sel+1), so 2 gives 1 MHz).
- TIMER_W, 16, interval timer width (8..16).
- LED_RESET, 8'hC3, reset value of port 0.
- ANIM_SHIFT, 16, animation step period of 2^ANIM_SHIFT master clocks.

Ports:
- clock  in  1  8 MHz master clock.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  block select from the address decoder, active low.
- rw  in  1  6502 R/W; 1 = read.
- addr  in  4  register offset.
- data_in  in  8  CPU write data.
- data_out  out  8  read data.
- data_oe  out  1  drive enable for the data bus.
- clockout  out  1  CPU clock (phi2).
- ports  out  8*NUM_PORTS  output registers, port n at bits [8n+7:8n].
- leds  out  8  port 0, or the animation pattern while animating.
- irq_n  out  1  timer interrupt, active low.

Behaviour:
- Reset values:
  - Divider counter = 0, clockout = 0, div_sel = DIV_SEL_RESET.
  - Port 0 = LED_RESET, other ports = 0.
  - Timer count, reload, ctrl and pending = 0, irq_n = 1.
  - anim = 1, animation pattern = 8'b00000001.
  - data_oe = 0.
- Reset asserted mid-operation returns every register to these values immediately.
- Divider:
  - cnt increments every clock and wraps at 2^DIV_W.
  - clockout = cnt[div_sel], registered.
  - A written div_sel goes to pending_sel first; it is copied to div_sel only on the cycle cnt is all-ones, so there is no runt pulse.
  - Worst-case switch latency is 2^DIV_W clocks.
  - Writes with sel >= DIV_W saturate to DIV_W-1.
- tick: one-clock pulse on the clock where the registered clockout goes 1 -> 0 (phi2 falling edge).
- Bus write:
  - Commits on tick when cs_n=0 and rw=0.
  - Exactly one commit per CPU cycle, regardless of how many master clocks the cycle spans.
- Bus read:
  - data_oe = ~cs_n & rw & clockout.
  - data_out is combinational from addr.
  - Unmapped offsets read 8'h00 and ignore writes.
- Register map:
  - 0x0..NUM_PORTS-1: PORTn, R/W.
  - 0x8: CLKDIV, R/W; reads return the active div_sel, not pending_sel.
  - 0x9: TRELOAD_LO; 0xA: TRELOAD_HI (ignored when TIMER_W = 8).
  - 0xB: TCTRL, bits: 0 = enable, 1 = irq_en, 2 = oneshot, 7 = pending.
    - Read returns {pending, 4'b0, oneshot, irq_en, enable}.
    - Writing bit7=1 clears pending.
  - 0xC: ANIM, bit 0, R/W.
- Timer (advances on tick only):
  - A TCTRL write with enable 0 -> 1 loads count = reload.
  - While enabled and count != 0: count decrements.
  - When count == 0: pending is set; then count = reload if periodic, or enable is cleared if oneshot.
  - reload = 0 with enable = 1 sets pending every tick.
  - A pending clear and a new expiry in the same tick leave pending = 1 (set wins).
  - irq_n = ~(pending & irq_en), registered.
- Animation:
  - While anim = 1, the pattern rotates left one bit every 2^ANIM_SHIFT clocks (bit 7 wraps to bit 0) and leds = pattern; otherwise leds = port 0.
  - Writing ANIM = 0 stops the rotation and holds the pattern.
  - ports[7:0] always reflects the PORT0 register.

Decomposition:
- Package sysctl_pkg holds:
  - register offset constants (PORT_BASE, CLKDIV_ADDR, TRELOAD_LO_ADDR, TRELOAD_HI_ADDR, TCTRL_ADDR, ANIM_ADDR);
  - TCTRL bit indices;
  - the animation reset pattern.
- One sub-module, sysctl_timer, contains the reload, count, oneshot and pending logic, with a tick input and a write-strobe interface.
- The divider, ports, animation and bus decode stay in sysctl_regs.

Test Plan:
- Reset, then idle with DIV_SEL_RESET=2 -> clockout has period 8 clocks at 50% duty; leds follow the rotating pattern 01, 02, 04 ... 80, 01; irq_n = 1; port 0 = C3.
- Write ANIM=0, then PORT0=0x5A with cs_n held low for the whole 8-clock CPU cycle -> leds = 5A one clock after tick; exactly one commit occurs; reads of 0x0 and 0xC return 5A and 00.
- Write CLKDIV=0 mid-count -> clockout stays at period 8 until cnt reaches all-ones, then switches to period 2 with no pulse shorter than 1 clock; reading 0x8 returns 2 until the switch and 0 after.
- Write TRELOAD_LO=3, then TCTRL=0x03 -> irq_n falls after 4 ticks and again 4 ticks later; writing TCTRL=0x83 raises irq_n on the next clock.
- Write TCTRL=0x07 (oneshot) with reload 0 -> pending is set on the first tick; a read of 0xB returns 0x86; there is no second expiry.
- Assert reset while the timer is running and anim=0 -> all outputs return to their reset values asynchronously; irq_n = 1 and clockout = 0 within the same clock.
